// File: rtl/voltage_link_master.sv
// Initiator and receiver for the FPGA-to-Pi voltage link.
//
// On a request it runs one 13-period sclk frame: period 0 with start low to
// clear the transmitter's start history, then periods 1..12 with start high.
// The transmitter loads on the falling sclk edge of period 1 and shifts the
// 10-bit word out MSB-first on mosi while ncs is low. The word is sampled on
// the last clk cycle of each sclk high phase in periods 2..11, and ncs is
// checked low in those periods and high in period 12.
//
// Ports:
//   clk_i        system clock, all flops rising-edge
//   reset_i      synchronous active-high reset
//   req_i        frame request, level-sampled while idle
//   sclk_o       link clock, registered, idles low
//   start_o      frame start to the transmitter, registered
//   mosi_i       serial data from the transmitter (asynchronous)
//   ncs_i        transmitter chip-select, active low (asynchronous)
//   data_o       last received word
//   valid_o      one-cycle pulse when data_o and frame_err_o update
//   busy_o       a frame is in progress
//   frame_err_o  1 when an ncs check failed in the last completed frame
module voltage_link_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_i,
  output logic       sclk_o,
  output logic       start_o,
  input  logic       mosi_i,
  input  logic       ncs_i,
  output logic [9:0] data_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       frame_err_o
);

  // Last clk cycle index inside one sclk half-period.
  localparam logic [7:0] DivLast    = 8'(CLK_DIV - 1);
  localparam logic [3:0] FirstBit   = 4'd2;
  localparam logic [3:0] LastBit    = 4'd11;
  localparam logic [3:0] LastPeriod = 4'd12;

  typedef enum logic [0:0] {StIdle, StFrame} state_e;

  state_e      state_q;
  logic [3:0]  period_q;   // sclk period inside the frame, 0..12
  logic [7:0]  div_cnt_q;  // clk cycle inside the current half-phase
  logic        sclk_q;     // also serves as the half-phase indicator
  logic        start_q;
  logic        busy_q;
  logic        valid_q;
  logic [9:0]  shift_q;
  logic [9:0]  data_q;
  logic        err_q;
  logic        frame_err_q;

  // Two-flop synchronizers; ncs resets to its inactive (high) level.
  logic mosi_meta_q, mosi_sync_q;
  logic ncs_meta_q, ncs_sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      ncs_meta_q  <= 1'b1;
      ncs_sync_q  <= 1'b1;
    end else begin
      mosi_meta_q <= mosi_i;
      mosi_sync_q <= mosi_meta_q;
      ncs_meta_q  <= ncs_i;
      ncs_sync_q  <= ncs_meta_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      period_q    <= '0;
      div_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      shift_q     <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_i) begin
            // Period 0 begins now: sclk high, start still low.
            state_q   <= StFrame;
            busy_q    <= 1'b1;
            period_q  <= '0;
            div_cnt_q <= '0;
            sclk_q    <= 1'b1;
            start_q   <= 1'b0;
            shift_q   <= '0;
            err_q     <= 1'b0;
          end
        end

        StFrame: begin
          if (div_cnt_q != DivLast) begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end else begin
            div_cnt_q <= '0;
            if (sclk_q) begin
              // End of the high phase: this edge drives sclk low and samples.
              sclk_q <= 1'b0;
              if (period_q >= FirstBit && period_q <= LastBit) begin
                shift_q <= {shift_q[8:0], mosi_sync_q};
                if (ncs_sync_q) begin
                  err_q <= 1'b1;
                end
              end else if (period_q == LastPeriod) begin
                // Transmitter must have released ncs after the last bit.
                if (!ncs_sync_q) begin
                  err_q <= 1'b1;
                end
              end
            end else if (period_q == LastPeriod) begin
              // End of the last period: frame completes.
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              start_q     <= 1'b0;
              data_q      <= shift_q;
              frame_err_q <= err_q;
              valid_q     <= 1'b1;
            end else begin
              // Next period; start stays high from period 1 onward.
              period_q <= period_q + 4'd1;
              sclk_q   <= 1'b1;
              start_q  <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sclk_o      = sclk_q;
  assign start_o     = start_q;
  assign busy_o      = busy_q;
  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_voltage_link_master.sv
module tb_voltage_link_master;

  localparam int unsigned D = 4;
  localparam int unsigned FrameLen = 26 * D;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       sclk;
  logic       start;
  logic       mosi = 1'b0;
  logic       ncs = 1'b1;
  logic [9:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;

  always #5 clk = ~clk;

  voltage_link_master #(.CLK_DIV(D)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .req_i      (req),
    .sclk_o     (sclk),
    .start_o    (start),
    .mosi_i     (mosi),
    .ncs_i      (ncs),
    .data_o     (data),
    .valid_o    (valid),
    .busy_o     (busy),
    .frame_err_o(frame_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural transmitter, acting on sclk falling edges.
  logic [9:0] tx_voltage = '0;
  bit         tx_stuck = 1'b0;  // never release ncs
  bit         tx_force = 1'b0;  // ncs high for one data period
  logic       tx_start_prev = 1'b0;
  bit         tx_active = 1'b0;
  int         tx_idx = 0;
  logic [9:0] tx_sh = '0;
  int         tx_loads = 0;

  always @(negedge sclk) begin
    if (start === 1'b1 && tx_start_prev === 1'b0) begin
      tx_sh     <= tx_voltage;
      tx_idx    <= 9;
      tx_active <= 1'b1;
      mosi      <= tx_voltage[9];
      ncs       <= 1'b0;
      tx_loads  <= tx_loads + 1;
    end else if (tx_active) begin
      if (tx_idx == 0) begin
        tx_active <= 1'b0;
        mosi      <= 1'b0;
        ncs       <= tx_stuck ? 1'b0 : 1'b1;
      end else begin
        tx_idx <= tx_idx - 1;
        mosi   <= tx_sh[4'(tx_idx - 1)];
        ncs    <= (tx_force && (tx_idx - 1) == 5) ? 1'b1 : 1'b0;
      end
    end
    tx_start_prev <= start;
  end

  // Cycle-level reference: time since the accepting edge decides every output.
  int unsigned cyc = 0;
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  int unsigned m_t = 0;
  logic [9:0]  m_word = '0;
  bit          m_ferr = 1'b0;
  logic [9:0]  m_data = '0;
  bit          m_err = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_t     <= 0;
      m_data  <= '0;
      m_err   <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (!m_busy) begin
        if (req) begin
          m_busy <= 1'b1;
          m_t    <= 0;
          m_word <= tx_voltage;
          m_ferr <= tx_stuck | tx_force;
        end
      end else if (m_t + 1 == FrameLen) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_data  <= m_word;
        m_err   <= m_ferr;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("sclk", 32'(sclk), 32'(m_busy && ((m_t % (2 * D)) < D)));
      check("start", 32'(start), 32'(m_busy && (m_t >= 2 * D)));
      check("busy", 32'(busy), 32'(m_busy));
      check("valid", 32'(valid), 32'(m_valid));
      check("data", 32'(data), 32'(m_data));
      check("frame_err", 32'(frame_err), 32'(m_err));
    end
  end

  // Record the cycle the frame became busy, for latency checks.
  logic        prev_busy = 1'b0;
  int unsigned t_start = 0;
  always @(negedge clk) begin
    if (busy === 1'b1 && prev_busy !== 1'b1) t_start <= cyc;
    prev_busy <= busy;
  end

  int unsigned rise_cnt = 0;
  always @(posedge sclk) rise_cnt <= rise_cnt + 1;

  task automatic wait_valid(input string name, output int unsigned vcyc);
    bit found = 1'b0;
    vcyc = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        found = 1'b1;
        vcyc  = cyc;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: valid not seen within 400 cycles", name);
    end
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_sclk"}, 32'(sclk), 32'd0);
    check({name, "_start"}, 32'(start), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_valid"}, 32'(valid), 32'd0);
    check({name, "_data"}, 32'(data), 32'd0);
    check({name, "_ferr"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    int unsigned v1;
    int unsigned v2;
    int unsigned rbase;
    int          lbase;
    int          cnt;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);

    // Reset while idle.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("idle_rst");

    // Single frame.
    tx_voltage = 10'h2A5;
    rbase = rise_cnt;
    pulse_req();
    wait_valid("single", v1);
    check("single_data", 32'(data), 32'h2A5);
    check("single_ferr", 32'(frame_err), 32'd0);
    check("single_latency", v1 - t_start, 32'd104);
    check("single_sclk_rises", rise_cnt - rbase, 32'd13);
    repeat (10) @(negedge clk);

    // Back-to-back with req held.
    tx_voltage = 10'h3FF;
    lbase = tx_loads;
    @(negedge clk);
    req = 1'b1;
    wait_valid("b2b_first", v1);
    check("b2b_data1", 32'(data), 32'h3FF);
    tx_voltage = 10'h000;
    @(negedge clk);
    req = 1'b0;
    wait_valid("b2b_second", v2);
    check("b2b_data2", 32'(data), 32'h000);
    check("b2b_spacing", v2 - v1, 32'd105);
    check("b2b_tx_loads", 32'(tx_loads - lbase), 32'd2);
    repeat (10) @(negedge clk);

    // ncs stuck low, then a good frame.
    tx_voltage = 10'h0AA;
    tx_stuck = 1'b1;
    pulse_req();
    wait_valid("stuck", v1);
    check("stuck_ferr", 32'(frame_err), 32'd1);
    check("stuck_data", 32'(data), 32'h0AA);
    tx_stuck = 1'b0;
    tx_voltage = 10'h155;
    repeat (5) @(negedge clk);
    pulse_req();
    wait_valid("good", v1);
    check("good_ferr", 32'(frame_err), 32'd0);
    check("good_data", 32'(data), 32'h155);
    repeat (5) @(negedge clk);

    // ncs high for one data period; a request mid-frame is ignored.
    tx_voltage = 10'h0F0;
    tx_force = 1'b1;
    pulse_req();
    repeat (40) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_valid("force", v1);
    check("force_ferr", 32'(frame_err), 32'd1);
    check("force_latency", v1 - t_start, 32'd104);
    tx_force = 1'b0;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || valid !== 1'b0) cnt++;
    end
    check("ignored_req_no_frame", 32'(cnt), 32'd0);

    // Abort in period 6 and recover.
    tx_voltage = 10'h2D2;
    pulse_req();
    repeat (12 * D + 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("abort");
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid === 1'b1) cnt++;
    end
    check("abort_no_valid", 32'(cnt), 32'd0);
    tx_voltage = 10'h1C3;
    pulse_req();
    wait_valid("recover", v1);
    check("recover_data", 32'(data), 32'h1C3);
    check("recover_ferr", 32'(frame_err), 32'd0);
    repeat (5) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
